// File: rtl/snes_pad_reader_if.sv
// Bundle of the pad-side GPIO lines and the mmio-side status words.
// master = the pad reader; slave = the pads/mmio side of the connection.
interface snes_pad_reader_if;
    logic        pad_data1;
    logic        pad_data2;
    logic        pad_latch;
    logic        pad_clk;
    logic [15:0] p1_buttons;
    logic [15:0] p2_buttons;
    logic [15:0] p1_edges;
    logic [15:0] p2_edges;
    logic        edge_clr;
    logic        frame_done;

    modport master (
        input  pad_data1,
        input  pad_data2,
        input  edge_clr,
        output pad_latch,
        output pad_clk,
        output p1_buttons,
        output p2_buttons,
        output p1_edges,
        output p2_edges,
        output frame_done
    );

    modport slave (
        output pad_data1,
        output pad_data2,
        output edge_clr,
        input  pad_latch,
        input  pad_clk,
        input  p1_buttons,
        input  p2_buttons,
        input  p1_edges,
        input  p2_edges,
        input  frame_done
    );
endinterface

// File: rtl/snes_pad_reader.sv
// Free-running poller for two SNES pads: latch, shift 16 bits per pad, then
// commit debounced active-high button words and sticky newly-pressed edges.
module snes_pad_reader #(
    parameter int unsigned TICK_DIV = 300,
    parameter int unsigned POLL_DIV = 833000
) (
    input  logic               clock,
    input  logic               reset,
    snes_pad_reader_if.master  bus
);

    localparam int unsigned LATCH_LEN = 2 * TICK_DIV;
    localparam int unsigned CNT_MAX   = (POLL_DIV > LATCH_LEN) ? POLL_DIV : LATCH_LEN;
    localparam int unsigned CW        = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic [3:0]      bit_idx;
    logic [3:0]      bit_idx_n;
    logic            high;
    logic            high_n;
    logic            capture;
    logic            latch_n;
    logic            clk_n;

    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [15:0]     raw1;
    logic [15:0]     raw2;
    logic [15:0]     prev1;
    logic [15:0]     prev2;
    logic [15:0]     new1;
    logic [15:0]     new2;
    logic            commit1;
    logic            commit2;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            high    <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            high    <= high_n;
        end
    end

    // Next-state logic; each state's dwell is measured by cnt counting from 0
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CW'(1);
        bit_idx_n = bit_idx;
        high_n    = high;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (cnt == CW'(POLL_DIV - 1)) begin
                    state_n = LATCH;
                    cnt_n   = '0;
                end
            end
            LATCH: begin
                if (cnt == CW'(LATCH_LEN - 1)) begin
                    state_n   = SHIFT;
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    high_n    = 1'b0;
                end
            end
            SHIFT: begin
                if (cnt == CW'(TICK_DIV - 1)) begin
                    cnt_n = '0;
                    if (!high) begin
                        high_n  = 1'b1;
                        capture = 1'b1;
                    end else if (bit_idx == 4'd15) begin
                        state_n = DONE;
                    end else begin
                        bit_idx_n = bit_idx + 4'd1;
                        high_n    = 1'b0;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Pad outputs are decoded from the next state so the registered pins
    // line up with the state they belong to.
    always_comb begin
        latch_n = (state_n == LATCH);
        clk_n   = !((state_n == SHIFT) && !high_n);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.pad_latch <= 1'b0;
            bus.pad_clk   <= 1'b1;
        end else begin
            bus.pad_latch <= latch_n;
            bus.pad_clk   <= clk_n;
        end
    end

    assign new1    = ~raw1;
    assign new2    = ~raw2;
    assign commit1 = (state == DONE) && (new1 == prev1);
    assign commit2 = (state == DONE) && (new2 == prev2);

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1          <= '1;
            sync2          <= '1;
            raw1           <= '1;
            raw2           <= '1;
            prev1          <= '0;
            prev2          <= '0;
            bus.p1_buttons <= '0;
            bus.p2_buttons <= '0;
            bus.p1_edges   <= '0;
            bus.p2_edges   <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            sync1 <= {sync1[0], bus.pad_data1};
            sync2 <= {sync2[0], bus.pad_data2};

            if (capture) begin
                raw1[bit_idx] <= sync1[1];
                raw2[bit_idx] <= sync2[1];
            end

            if (state == DONE) begin
                prev1 <= new1;
                prev2 <= new2;
            end

            // Clear first, then OR in fresh presses so a colliding clear keeps them
            bus.p1_edges <= (bus.edge_clr ? '0 : bus.p1_edges)
                          | (commit1 ? (new1 & ~bus.p1_buttons) : '0);
            bus.p2_edges <= (bus.edge_clr ? '0 : bus.p2_edges)
                          | (commit2 ? (new2 & ~bus.p2_buttons) : '0);

            if (commit1) bus.p1_buttons <= new1;
            if (commit2) bus.p2_buttons <= new2;

            bus.frame_done <= (state == DONE);
        end
    end

endmodule

// File: tb/tb_snes_pad_reader.sv
// Directed bench for snes_pad_reader with TICK_DIV=4, POLL_DIV=16 (frame = 153 cycles).
module tb_snes_pad_reader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        edge_clr = 1'b0;
    logic [15:0] press1 = '0;
    logic [15:0] press2 = '0;
    logic [15:0] sr1 = '1;
    logic [15:0] sr2 = '1;
    logic        clk_d = 1'b1;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    snes_pad_reader_if bus ();

    snes_pad_reader #(
        .TICK_DIV (4),
        .POLL_DIV (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Pad model: parallel load while latched, shift on each pad_clk rise
    always @(posedge clock) begin
        clk_d <= bus.pad_clk;
        if (bus.pad_latch) begin
            sr1 <= ~press1;
            sr2 <= ~press2;
        end else if (bus.pad_clk && !clk_d) begin
            sr1 <= {1'b1, sr1[15:1]};
            sr2 <= {1'b1, sr2[15:1]};
        end
    end

    assign bus.pad_data1 = sr1[0];
    assign bus.pad_data2 = sr2[0];
    assign bus.edge_clr  = edge_clr;

    task automatic step();
        @(negedge clock);
        cyc++;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic test_reset_framing();
        int falls;
        int first_fall;
        logic prev_clk;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        cyc = 0;
        vectors++;
        if ({bus.pad_latch, bus.pad_clk, bus.frame_done} !== 3'b010) begin
            miscompares++;
            $display("FAIL reset_pins: got latch/clk/done=%b expected 010",
                     {bus.pad_latch, bus.pad_clk, bus.frame_done});
        end
        falls = 0;
        first_fall = -1;
        prev_clk = bus.pad_clk;
        for (int c = 0; c <= 153; c++) begin
            if (c > 0) step();
            vectors++;
            if (bus.pad_latch !== (cyc >= 16 && cyc <= 23)) begin
                miscompares++;
                $display("FAIL frame_latch@%0d: got %b expected %b", cyc, bus.pad_latch,
                         (cyc >= 16 && cyc <= 23));
            end
            vectors++;
            if (bus.frame_done !== (cyc == 153)) begin
                miscompares++;
                $display("FAIL frame_done@%0d: got %b expected %b", cyc, bus.frame_done, (cyc == 153));
            end
            vectors++;
            if ({bus.p1_buttons, bus.p2_buttons, bus.p1_edges, bus.p2_edges} !== 64'h0) begin
                miscompares++;
                $display("FAIL frame_words@%0d: got %h expected 0", cyc,
                         {bus.p1_buttons, bus.p2_buttons, bus.p1_edges, bus.p2_edges});
            end
            if (prev_clk && !bus.pad_clk) begin
                falls++;
                if (first_fall < 0) first_fall = cyc;
            end
            prev_clk = bus.pad_clk;
        end
        vectors++;
        if (falls != 16) begin
            miscompares++;
            $display("FAIL clk_fall_count: got %0d expected 16", falls);
        end
        vectors++;
        if (first_fall != 24) begin
            miscompares++;
            $display("FAIL first_clk_fall: got %0d expected 24", first_fall);
        end
    endtask

    task automatic test_press_a();
        press1 = 16'h0100;
        step_to(306);
        vectors++;
        if ({bus.frame_done, bus.p1_buttons, bus.p1_edges} !== {1'b1, 16'h0000, 16'h0000}) begin
            miscompares++;
            $display("FAIL press_a_frame1: got done=%b btn=%h edg=%h expected 1 0000 0000",
                     bus.frame_done, bus.p1_buttons, bus.p1_edges);
        end
        step_to(459);
        vectors++;
        if (bus.p1_buttons !== 16'h0100) begin
            miscompares++;
            $display("FAIL press_a_buttons: got %h expected 0100", bus.p1_buttons);
        end
        vectors++;
        if (bus.p1_edges !== 16'h0100) begin
            miscompares++;
            $display("FAIL press_a_edges: got %h expected 0100", bus.p1_edges);
        end
        vectors++;
        if (bus.p2_buttons !== 16'h0000) begin
            miscompares++;
            $display("FAIL press_a_p2: got %h expected 0000", bus.p2_buttons);
        end
    endtask

    task automatic test_glitch();
        press1 = 16'h0108;
        step_to(612);
        press1 = 16'h0100;
        vectors++;
        if ({bus.p1_buttons, bus.p1_edges} !== {16'h0100, 16'h0100}) begin
            miscompares++;
            $display("FAIL glitch_f4: got btn=%h edg=%h expected 0100 0100", bus.p1_buttons, bus.p1_edges);
        end
        step_to(765);
        vectors++;
        if ({bus.p1_buttons, bus.p1_edges} !== {16'h0100, 16'h0100}) begin
            miscompares++;
            $display("FAIL glitch_f5: got btn=%h edg=%h expected 0100 0100", bus.p1_buttons, bus.p1_edges);
        end
        step_to(918);
        vectors++;
        if ({bus.p1_buttons, bus.p1_edges} !== {16'h0100, 16'h0100}) begin
            miscompares++;
            $display("FAIL glitch_f6: got btn=%h edg=%h expected 0100 0100", bus.p1_buttons, bus.p1_edges);
        end
    endtask

    task automatic test_clear_collision();
        press1 = 16'h0110;
        step_to(1071);
        vectors++;
        if ({bus.p1_buttons, bus.p1_edges} !== {16'h0100, 16'h0100}) begin
            miscompares++;
            $display("FAIL collide_f7: got btn=%h edg=%h expected 0100 0100", bus.p1_buttons, bus.p1_edges);
        end
        step_to(1223);
        edge_clr = 1'b1;
        step();
        edge_clr = 1'b0;
        vectors++;
        if (bus.p1_edges !== 16'h0010) begin
            miscompares++;
            $display("FAIL collide_edges: got %h expected 0010", bus.p1_edges);
        end
        vectors++;
        if (bus.p1_buttons !== 16'h0110) begin
            miscompares++;
            $display("FAIL collide_buttons: got %h expected 0110", bus.p1_buttons);
        end
    endtask

    task automatic test_release();
        press1 = 16'h0000;
        press2 = 16'h0801;
        step_to(1377);
        vectors++;
        if ({bus.p1_buttons, bus.p1_edges, bus.p2_buttons} !== {16'h0110, 16'h0010, 16'h0000}) begin
            miscompares++;
            $display("FAIL release_f9: got btn=%h edg=%h p2=%h expected 0110 0010 0000",
                     bus.p1_buttons, bus.p1_edges, bus.p2_buttons);
        end
        step_to(1530);
        vectors++;
        if (bus.p1_buttons !== 16'h0000) begin
            miscompares++;
            $display("FAIL release_buttons: got %h expected 0000", bus.p1_buttons);
        end
        vectors++;
        if (bus.p1_edges !== 16'h0010) begin
            miscompares++;
            $display("FAIL release_edges: got %h expected 0010", bus.p1_edges);
        end
        vectors++;
        if ({bus.p2_buttons, bus.p2_edges} !== {16'h0801, 16'h0801}) begin
            miscompares++;
            $display("FAIL pad2_commit: got btn=%h edg=%h expected 0801 0801", bus.p2_buttons, bus.p2_edges);
        end
    endtask

    task automatic test_edge_clr();
        step_to(1540);
        edge_clr = 1'b1;
        step();
        edge_clr = 1'b0;
        vectors++;
        if ({bus.p1_edges, bus.p2_edges} !== 32'h0) begin
            miscompares++;
            $display("FAIL edge_clr: got p1=%h p2=%h expected 0000 0000", bus.p1_edges, bus.p2_edges);
        end
        vectors++;
        if (bus.p2_buttons !== 16'h0801) begin
            miscompares++;
            $display("FAIL edge_clr_buttons: got %h expected 0801", bus.p2_buttons);
        end
    endtask

    task automatic test_reset_mid_frame();
        step_to(1612);
        vectors++;
        if (bus.pad_clk !== 1'b0) begin
            miscompares++;
            $display("FAIL slot7_low: got pad_clk=%b expected 0", bus.pad_clk);
        end
        reset = 1'b1;
        step();
        vectors++;
        if ({bus.pad_latch, bus.pad_clk, bus.frame_done} !== 3'b010) begin
            miscompares++;
            $display("FAIL midreset_pins: got %b expected 010", {bus.pad_latch, bus.pad_clk, bus.frame_done});
        end
        vectors++;
        if ({bus.p1_buttons, bus.p2_buttons, bus.p1_edges, bus.p2_edges} !== 64'h0) begin
            miscompares++;
            $display("FAIL midreset_words: got %h expected 0",
                     {bus.p1_buttons, bus.p2_buttons, bus.p1_edges, bus.p2_edges});
        end
        reset = 1'b0;
        cyc = 0;
        step_to(15);
        vectors++;
        if (bus.pad_latch !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_latch15: got %b expected 0", bus.pad_latch);
        end
        step();
        vectors++;
        if (bus.pad_latch !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_latch16: got %b expected 1", bus.pad_latch);
        end
        step_to(153);
        vectors++;
        if ({bus.frame_done, bus.p2_buttons} !== {1'b1, 16'h0000}) begin
            miscompares++;
            $display("FAIL midreset_first_frame: got done=%b p2=%h expected 1 0000",
                     bus.frame_done, bus.p2_buttons);
        end
    endtask

    initial begin
        test_reset_framing();
        test_press_a();
        test_glitch();
        test_clear_collision();
        test_release();
        test_edge_clr();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/snes_pad_reader.md
# snes_pad_reader

Polls two SNES-style game controllers over the GPIO header (shared latch and clock outputs, one serial data input per pad) and presents debounced, active-high button words to the memory-mapped I/O block. It sits directly upstream of the mmio block: mmio exposes its outputs as read-only words and pulses `edge_clr` when the processor reads the edge words. Polling is free-running; no processor involvement is needed to keep the state current.

## Interface
- `TICK_DIV`, 300: clock cycles per half bit period on `pad_clk`. Must be ≥ 4.
- `POLL_DIV`, 833000: idle cycles between frames (~60 Hz at 50 MHz). Must be ≥ 1.
- `clock` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `pad_data1` in 1: serial data from pad 1. Asynchronous, active-low (pressed = 0).
- `pad_data2` in 1: serial data from pad 2. Same convention as pad 1.
- `pad_latch` out 1: latch pulse to both pads.
- `pad_clk` out 1: shift clock to both pads. Idles high.
- `p1_buttons` out 16: committed pad 1 state, active-high. Bit order: 0 B, 1 Y, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right, 8 A, 9 X, 10 L, 11 R, 12–15 ID.
- `p2_buttons` out 16: committed pad 2 state, same format as `p1_buttons`.
- `p1_edges` out 16: sticky newly-pressed bits for pad 1.
- `p2_edges` out 16: sticky newly-pressed bits for pad 2.
- `edge_clr` in 1: single-cycle pulse from mmio. Clears both edge words.
- `frame_done` out 1: one-cycle pulse at the end of every frame.

## Operation
- **Input synchronisation:** two-flop synchronizer on each `pad_dataN`. All sampling uses the synchronized value.
- **States:** IDLE → LATCH → SHIFT → DONE → IDLE.
- **IDLE:** `pad_latch` = 0, `pad_clk` = 1. Lasts exactly POLL_DIV cycles.
- **LATCH:** `pad_latch` = 1, `pad_clk` = 1. Lasts exactly 2·TICK_DIV cycles.
- **SHIFT:** 16 bit slots, i = 0..15. Each slot is:
  - low phase: `pad_clk` = 0 for TICK_DIV cycles; in the last low cycle, the synchronized data of each pad is captured into raw bit i;
  - high phase: `pad_clk` = 1 for TICK_DIV cycles.
  - The bit counter is 4 bits. SHIFT exits after the high phase of slot 15.
- **DONE:** lasts 1 cycle, then returns to IDLE. For each pad, independently:
  - new = ~raw.
  - If new equals that pad's previous-frame sample (`prevN`), commit: `pN_edges` ← `pN_edges` | (new & ~`pN_buttons`), and `pN_buttons` ← new.
  - Otherwise no change. This is the two-consecutive-frame debounce.
  - `prevN` ← new, always.
- **Release:** releasing a button clears its bit in `pN_buttons` on commit. It never sets an edge bit.
- **`edge_clr`:** clears both edge words. If it arrives in the same cycle as a commit that sets edge bits, the newly set bits survive and all other bits clear.
- **Frame length:** F = POLL_DIV + 34·TICK_DIV + 1 cycles.

## Timing
- **Reset values** (in the cycle after `reset` is sampled high):
  - state = IDLE, idle counter = 0;
  - `pad_latch` = 0, `pad_clk` = 1;
  - `p1_buttons`, `p2_buttons`, `p1_edges`, `p2_edges` = 0;
  - `frame_done` = 0;
  - `prev1` = `prev2` = 0;
  - synchronizer flops = 1.
- **Reset priority:** reset overrides everything, including mid-frame. A partial frame is discarded and never commits.
- **Frame timing** (cycle 0 = first cycle with `reset` low):
  - `pad_latch` rises at cycle POLL_DIV.
  - The first `pad_clk` fall is at POLL_DIV + 2·TICK_DIV.
- **Output registration:** all outputs are registered. Committed `pN_buttons`/`pN_edges` and `frame_done` become visible together, in the cycle after DONE.
- **`edge_clr` latency:** 1 cycle (edges read 0 on the next cycle).
- **Debounce latency:** a stable button change reaches `pN_buttons` one or two frames after it is first sampled.

## Test plan
Bench parameters: TICK_DIV = 4, POLL_DIV = 16, so F = 153. Pad model shifts on each `pad_clk` rise.

- **Reset/framing:** release reset →
  - `pad_latch` high during cycles 16–23;
  - exactly 16 `pad_clk` falls, the first at cycle 24;
  - `frame_done` pulse at cycle 153;
  - all button and edge words 0 throughout.
- **Press A on pad 1** (bit 8 low, others high), held:
  - frame 1 (prev = 0 ≠ 0x0100): no change;
  - frame 2: `p1_buttons` = 16'h0100, `p1_edges` = 16'h0100;
  - `p2_buttons` stays 0.
- **Glitch:** Start pressed for one frame only, then released → `p1_buttons` and `p1_edges` never change.
- **Clear collision:** `p1_edges` = 0x0100; A held, then Up pressed. Pulse `edge_clr` in the commit cycle of Up → `p1_edges` = 16'h0010, `p1_buttons` = 16'h0110.
- **Release:** from 0x0110, release all buttons → two frames later `p1_buttons` = 0 and `p1_edges` unchanged.
- **Reset mid-frame:** assert reset during bit slot 7 →
  - next cycle: `pad_latch` = 0, `pad_clk` = 1, all words 0;
  - after release, the new `pad_latch` rise is at cycle 16.
